// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core sequencer: FSM encodings, reset PC,
// NOP encoding, stage indices for the flush vector and small PC helpers.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    localparam logic [2:0] ST_BOOT    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_LDSTALL = 3'd2;
    localparam logic [2:0] ST_IMWAIT  = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    // Bit positions within flush_o; bit0 is the youngest stage (fetch).
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;

    function automatic logic [31:0] pc_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: +1 on every clock with en_i high, wraps modulo 2^CNT_W.
// Output is registered; count reflects events up to the previous edge.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Fetch-PC owner and pipeline sequencer: redirects, load-use and imem stalls, squash window.
// All outputs registered; one-cycle latency from inputs to pc/stall/flush.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          FLUSH_DEPTH = 3,
    parameter int          CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   br_valid_i,
    input  logic                   br_taken_i,
    input  logic [31:0]            br_target_i,
    input  logic                   load_use_i,
    input  logic                   imem_ready_i,
    output logic [31:0]            pc_o,
    output logic                   fetch_req_o,
    output logic                   stall_o,
    output logic                   bubble_o,
    output logic [FLUSH_DEPTH-1:0] flush_o,
    output logic                   trap_o,
    output logic [CNT_W-1:0]       redirect_cnt_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam int SQ_W = 3;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_DEPTH - 1);

    logic [2:0]             state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   fetch_q, fetch_d;
    logic                   stall_q, stall_d;
    logic                   bubble_q, bubble_d;
    logic [FLUSH_DEPTH-1:0] flush_q, flush_d;
    logic                   trap_q, trap_d;
    logic [SQ_W-1:0]        squash_q, squash_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [31:0]            pend_pc_q, pend_pc_d;

    logic br_acc;
    logic squash_idle;
    logic redir_inc;
    logic stall_cnt_en;

    assign squash_idle = (squash_q == '0);
    assign br_acc      = br_valid_i & br_taken_i & squash_idle;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stall_d    = 1'b0;
        bubble_d   = 1'b0;
        flush_d    = '0;
        trap_d     = trap_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        squash_d   = squash_idle ? squash_q : squash_q - SQ_W'(1);
        redir_inc  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN, ST_LDSTALL: begin
                if (br_acc && misaligned(br_target_i)) begin
                    trap_d  = 1'b1;
                    flush_d = '1;
                    stall_d = 1'b1;
                    state_d = ST_HALT;
                end else if (br_acc) begin
                    pc_d      = br_target_i;
                    flush_d   = '1;
                    squash_d  = SQ_LOAD;
                    redir_inc = 1'b1;
                    state_d   = ST_RUN;
                end else if (load_use_i && squash_idle) begin
                    stall_d  = 1'b1;
                    bubble_d = 1'b1;
                    state_d  = ST_LDSTALL;
                end else if (!imem_ready_i) begin
                    stall_d = 1'b1;
                    state_d = ST_IMWAIT;
                end else begin
                    pc_d    = pc_seq(pc_q);
                    state_d = ST_RUN;
                end
            end

            ST_IMWAIT: begin
                stall_d = 1'b1;
                // Only the first resolution during the wait is right-path.
                if (br_acc && !pend_vld_q && misaligned(br_target_i)) begin
                    trap_d  = 1'b1;
                    flush_d = '1;
                    state_d = ST_HALT;
                end else if (br_acc && !pend_vld_q) begin
                    flush_d   = '1;
                    squash_d  = SQ_LOAD;
                    redir_inc = 1'b1;
                    if (imem_ready_i) begin
                        pc_d    = br_target_i;
                        stall_d = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = br_target_i;
                    end
                end else if (imem_ready_i) begin
                    pc_d       = pend_vld_q ? pend_pc_q : pc_seq(pc_q);
                    pend_vld_d = 1'b0;
                    stall_d    = 1'b0;
                    state_d    = ST_RUN;
                end
            end

            ST_HALT: begin
                stall_d = 1'b1;
            end

            default: begin
                stall_d = 1'b1;
                state_d = ST_HALT;
            end
        endcase

        fetch_d = (state_d == ST_RUN) || (state_d == ST_LDSTALL) || (state_d == ST_IMWAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fetch_q    <= 1'b0;
            stall_q    <= 1'b1;
            bubble_q   <= 1'b0;
            flush_q    <= '0;
            trap_q     <= 1'b0;
            squash_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_q    <= fetch_d;
            stall_q    <= stall_d;
            bubble_q   <= bubble_d;
            flush_q    <= flush_d;
            trap_q     <= trap_d;
            squash_q   <= squash_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // BOOT and HALT hold stall high but are not pipeline stalls.
    assign stall_cnt_en = stall_q && (state_q != ST_BOOT) && (state_q != ST_HALT);

    perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (redir_inc),
        .cnt_o (redirect_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_cnt_en),
        .cnt_o (stall_cnt_o)
    );

    assign pc_o        = pc_q;
    assign fetch_req_o = fetch_q;
    assign stall_o     = stall_q;
    assign bubble_o    = bubble_q;
    assign flush_o     = flush_q;
    assign trap_o      = trap_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each step queues its expected outputs and
// checks them one clock later.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        load_use_i;
    logic        imem_ready_i;
    logic [31:0] pc_o;
    logic        fetch_req_o;
    logic        stall_o;
    logic        bubble_o;
    logic [2:0]  flush_o;
    logic        trap_o;
    logic [31:0] redirect_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_chk;
    int n_fail;

    typedef struct packed {
        logic [31:0] pc;
        logic        stall;
        logic        bubble;
        logic [2:0]  flush;
        logic        fetch;
    } exp_t;

    exp_t exp_q[$];

    pipeline_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_DEPTH (3),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid_i     (br_valid_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .load_use_i     (load_use_i),
        .imem_ready_i   (imem_ready_i),
        .pc_o           (pc_o),
        .fetch_req_o    (fetch_req_o),
        .stall_o        (stall_o),
        .bubble_o       (bubble_o),
        .flush_o        (flush_o),
        .trap_o         (trap_o),
        .redirect_cnt_o (redirect_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue what the registered outputs must be
    // after the next edge, then pop and compare once the edge has passed.
    task automatic cyc(input string tag, input logic bv, input logic [31:0] tgt,
                       input logic lu, input logic rdy,
                       input logic [31:0] e_pc, input logic e_stall, input logic e_bub,
                       input logic [2:0] e_flush, input logic e_fetch);
        exp_t e;
        br_valid_i   = bv;
        br_taken_i   = bv;
        br_target_i  = tgt;
        load_use_i   = lu;
        imem_ready_i = rdy;
        exp_q.push_back('{pc: e_pc, stall: e_stall, bubble: e_bub, flush: e_flush, fetch: e_fetch});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"},     pc_o,               e.pc);
        chk({tag, ".stall"},  {31'd0, stall_o},   {31'd0, e.stall});
        chk({tag, ".bubble"}, {31'd0, bubble_o},  {31'd0, e.bubble});
        chk({tag, ".flush"},  {29'd0, flush_o},   {29'd0, e.flush});
        chk({tag, ".fetch"},  {31'd0, fetch_req_o}, {31'd0, e.fetch});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},     pc_o,                 32'h0);
        chk({tag, ".fetch"},  {31'd0, fetch_req_o}, 32'd0);
        chk({tag, ".stall"},  {31'd0, stall_o},     32'd1);
        chk({tag, ".bubble"}, {31'd0, bubble_o},    32'd0);
        chk({tag, ".flush"},  {29'd0, flush_o},     32'd0);
        chk({tag, ".trap"},   {31'd0, trap_o},      32'd0);
        chk({tag, ".rcnt"},   redirect_cnt_o,       32'd0);
        chk({tag, ".scnt"},   stall_cnt_o,          32'd0);
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        br_valid_i   = 1'b0;
        br_taken_i   = 1'b0;
        br_target_i  = 32'h0;
        load_use_i   = 1'b0;
        imem_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst0");

        rst = 1'b0;
        chk("boot.pc", pc_o, 32'h0);
        chk("boot.fetch", {31'd0, fetch_req_o}, 32'd0);
        cyc("run0",  1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 3'b000, 1'b1);
        cyc("seq4",  1'b0, 32'h0, 1'b0, 1'b1, 32'h4,  1'b0, 1'b0, 3'b000, 1'b1);
        cyc("seq8",  1'b0, 32'h0, 1'b0, 1'b1, 32'h8,  1'b0, 1'b0, 3'b000, 1'b1);
        cyc("seqC",  1'b0, 32'h0, 1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 3'b000, 1'b1);

        // Taken redirect, then two wrong-path resolutions inside the squash window.
        cyc("br100", 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 3'b111, 1'b1);
        chk("br100.rcnt", redirect_cnt_o, 32'd1);
        cyc("sq1",   1'b1, 32'h300, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("sq2",   1'b1, 32'h300, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("sq.rcnt", redirect_cnt_o, 32'd1);

        cyc("lu",    1'b0, 32'h0, 1'b1, 1'b1, 32'h108, 1'b1, 1'b1, 3'b000, 1'b1);
        cyc("lu_end",1'b0, 32'h0, 1'b0, 1'b1, 32'h10C, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("lu.scnt", stall_cnt_o, 32'd1);

        // Load-use coinciding with a taken branch: redirect only.
        cyc("lubr",  1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 3'b111, 1'b1);
        chk("lubr.rcnt", redirect_cnt_o, 32'd2);
        cyc("lubr1", 1'b0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("lubr2", 1'b0, 32'h0, 1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("lubr.scnt", stall_cnt_o, 32'd1);

        // Three imem wait cycles, branch to 0x200 arriving in the second.
        cyc("imw1",  1'b0, 32'h0,   1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 3'b000, 1'b1);
        cyc("imw2",  1'b1, 32'h200, 1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 3'b111, 1'b1);
        chk("imw.rcnt", redirect_cnt_o, 32'd3);
        cyc("imw3",  1'b0, 32'h0,   1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 3'b000, 1'b1);
        cyc("imwr",  1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("imw.scnt", stall_cnt_o, 32'd4);
        cyc("imwn",  1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 3'b000, 1'b1);

        // PC wrap at the top of the address space.
        cyc("brtop", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 3'b111, 1'b1);
        cyc("top",   1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("wrap",  1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("wrap.rcnt", redirect_cnt_o, 32'd4);

        // Misaligned target traps and freezes everything.
        cyc("mis",   1'b1, 32'h102, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 3'b111, 1'b0);
        chk("mis.trap", {31'd0, trap_o}, 32'd1);
        chk("mis.rcnt", redirect_cnt_o, 32'd4);
        cyc("halt1", 1'b1, 32'h100, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 3'b000, 1'b0);
        cyc("halt2", 1'b0, 32'h0,   1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 3'b000, 1'b0);
        chk("halt.trap", {31'd0, trap_o}, 32'd1);
        chk("halt.scnt", stall_cnt_o, 32'd4);

        rst = 1'b1;
        #1;
        chk_reset_state("rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("r1run", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("r1seq", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 3'b000, 1'b1);

        // Reset while a redirect is pending in IMWAIT must drop it.
        cyc("pw1",   1'b0, 32'h0,   1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 3'b000, 1'b1);
        cyc("pw2",   1'b1, 32'h200, 1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 3'b111, 1'b1);
        br_valid_i = 1'b0;
        br_taken_i = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_state("rst2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("r2run", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("r2s4",  1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc("r2s8",  1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("r2.rcnt", redirect_cnt_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
